gb_serial: RTL and testbench

//  Link-port serial controller: owns SB (FF01) and SC (FF02) on the CPU bus, same bus pattern as gb_timer.

---
 rtl/gb_serial.sv | 165 ++++++++++++++++
 tb/tb_gb_serial.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/gb_serial.sv
// Link-port serial controller owning SB (FF01) and SC (FF02).
// Define SERIAL_CAPTURE_EN to add the cap_valid/cap_data logging ports.
module gb_serial #(
  parameter int CLKS_PER_BIT = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [7:0]  data_i,
  input  logic        wren,
  output logic [7:0]  data_o,
  output logic        irq_serial,
  output logic        sout,
  input  logic        sin,
  output logic        sclk_o,
  input  logic        sclk_i
`ifdef SERIAL_CAPTURE_EN
  ,
  output logic        cap_valid,
  output logic [7:0]  cap_data
`endif
);

  localparam int DW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLKS_PER_BIT - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLKS_PER_BIT / 2);

  typedef enum logic [1:0] {
    IDLE,
    XFER_INT,
    XFER_EXT
  } state_t;

  state_t          r_state;
  logic [7:0]      r_sb;
  logic            r_sc_start;
  logic            r_sc_clk;
  logic [2:0]      r_bit_cnt;
  logic [DW-1:0]   r_div_cnt;
  logic            r_irq;
  logic [1:0]      r_sync;
  logic            r_sclk_q;

  state_t          w_state_nxt;
  logic [7:0]      w_sb_nxt;
  logic            w_start_nxt;
  logic            w_clk_nxt;
  logic [2:0]      w_bit_nxt;
  logic [DW-1:0]   w_div_nxt;
  logic            w_irq_nxt;
  logic            w_shift;
  logic            w_wr_sb;
  logic            w_wr_sc;
  logic            w_ext_rise;

  assign w_wr_sb    = wren && (addr == 16'hFF01);
  assign w_wr_sc    = wren && (addr == 16'hFF02);
  assign w_ext_rise = r_sync[1] & ~r_sclk_q;

  always_comb begin
    w_state_nxt = r_state;
    w_sb_nxt    = r_sb;
    w_start_nxt = r_sc_start;
    w_clk_nxt   = r_sc_clk;
    w_bit_nxt   = r_bit_cnt;
    w_div_nxt   = r_div_cnt;
    w_irq_nxt   = 1'b0;
    w_shift     = 1'b0;
    unique case (r_state)
      IDLE: w_div_nxt = '0;
      XFER_INT: begin
        if (r_div_cnt == DIV_LAST) begin
          w_shift   = 1'b1;
          w_div_nxt = '0;
        end else begin
          w_div_nxt = r_div_cnt + DW'(1);
        end
      end
      XFER_EXT: w_shift = w_ext_rise;
      default: w_state_nxt = IDLE;
    endcase
    if (w_shift) begin
      w_sb_nxt  = {r_sb[6:0], sin};
      w_bit_nxt = r_bit_cnt + 3'd1;
      if (r_bit_cnt == 3'd7) begin
        w_state_nxt = IDLE;
        w_start_nxt = 1'b0;
        w_irq_nxt   = 1'b1;
        w_div_nxt   = '0;
      end
    end
    // CPU write to SB beats a coincident shift; bit_cnt still advances
    if (w_wr_sb)
      w_sb_nxt = data_i;
    if (w_wr_sc) begin
      w_start_nxt = data_i[7];
      w_clk_nxt   = data_i[0];
      w_bit_nxt   = 3'd0;
      w_div_nxt   = '0;
      w_irq_nxt   = 1'b0;
      if (!data_i[7])
        w_state_nxt = IDLE;
      else if (data_i[0])
        w_state_nxt = XFER_INT;
      else
        w_state_nxt = XFER_EXT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_sb       <= 8'h00;
      r_sc_start <= 1'b0;
      r_sc_clk   <= 1'b0;
      r_bit_cnt  <= 3'd0;
      r_div_cnt  <= '0;
      r_irq      <= 1'b0;
      r_sync     <= 2'b00;
      r_sclk_q   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_sb       <= w_sb_nxt;
      r_sc_start <= w_start_nxt;
      r_sc_clk   <= w_clk_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_div_cnt  <= w_div_nxt;
      r_irq      <= w_irq_nxt;
      r_sync     <= {r_sync[0], sclk_i};
      r_sclk_q   <= r_sync[1];
    end
  end

  assign irq_serial = r_irq;
  assign sout       = (r_state == IDLE) ? 1'b1 : r_sb[7];
  assign sclk_o     = (r_state == XFER_INT) ? (r_div_cnt >= DIV_HALF) : 1'b1;

  always_comb begin
    data_o = 8'hFF;
    if (addr == 16'hFF01)
      data_o = r_sb;
    else if (addr == 16'hFF02)
      data_o = {r_sc_start, 6'b111111, r_sc_clk};
  end

`ifdef SERIAL_CAPTURE_EN
  logic       r_cap_valid;
  logic [7:0] r_cap_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cap_valid <= 1'b0;
      r_cap_data  <= 8'h00;
    end else begin
      r_cap_valid <= w_wr_sc && (data_i == 8'h81);
      if (w_wr_sc && (data_i == 8'h81))
        r_cap_data <= r_sb;
    end
  end

  assign cap_valid = r_cap_valid;
  assign cap_data  = r_cap_data;
`endif

endmodule

// File: tb/tb_gb_serial.sv
// Directed bench for gb_serial with CLKS_PER_BIT=8.
// Expected sout bits and SB results flow through a scoreboard queue.
module tb_gb_serial;
  localparam int N = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] addr = 16'hFF10;
  logic [7:0]  data_i = 8'h00;
  logic        wren = 1'b0;
  logic        sin = 1'b1;
  logic        sclk_i = 1'b0;
  logic [7:0]  data_o;
  logic        irq_serial;
  logic        sout;
  logic        sclk_o;
`ifdef SERIAL_CAPTURE_EN
  logic        cap_valid;
  logic [7:0]  cap_data;
`endif

  gb_serial #(.CLKS_PER_BIT(N)) dut (
    .clk(clk),
    .reset(reset),
    .addr(addr),
    .data_i(data_i),
    .wren(wren),
    .data_o(data_o),
    .irq_serial(irq_serial),
    .sout(sout),
    .sin(sin),
    .sclk_o(sclk_o),
    .sclk_i(sclk_i)
`ifdef SERIAL_CAPTURE_EN
    ,
    .cap_valid(cap_valid),
    .cap_data(cap_data)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int irq_cnt = 0;
  logic [7:0] exp_q[$];

  always @(negedge clk)
    if (irq_serial === 1'b1) irq_cnt++;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a;
    data_i = d;
    wren = 1'b1;
    @(posedge clk);
    #1;
    wren = 1'b0;
    addr = 16'hFF10;
  endtask

  task automatic rd(input logic [15:0] a, input string tag,
                    input logic [7:0] exp);
    @(negedge clk);
    addr = a;
    #1;
    chk(tag, data_o, exp);
    addr = 16'hFF10;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [7:0] pat;
    logic [7:0] e;
    int i0;
    int ph;

    // 1: reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    rd(16'hFF01, "rst_sb", 8'h00);
    rd(16'hFF02, "rst_sc", 8'h7E);
    rd(16'hFF10, "rst_other", 8'hFF);
    chk("rst_sout", {7'd0, sout}, 8'h01);
    chk("rst_sclk", {7'd0, sclk_o}, 8'h01);
    chk("rst_irq", {7'd0, irq_serial}, 8'h00);

    // 2: internal transfer of A5 with sin=1
    pat = 8'hA5;
    sin = 1'b1;
    cpu_wr(16'hFF01, pat);
    rd(16'hFF01, "sb_wr", 8'hA5);
    cpu_wr(16'hFF02, 8'h81);
    for (int b = 7; b >= 0; b--) exp_q.push_back({7'd0, pat[b]});
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      ph = (c - 1) % N;
      if (c <= 8 * N && ph == N / 2) begin
        e = exp_q.pop_front();
        chk("int_sout", {7'd0, sout}, e);
      end
      if (c <= 8 * N)
        chk("int_sclk", {7'd0, sclk_o}, (ph >= N / 2) ? 8'h01 : 8'h00);
      else
        chk("int_sclk_idle", {7'd0, sclk_o}, 8'h01);
      chk("int_irq", {7'd0, irq_serial}, (c == 8 * N + 1) ? 8'h01 : 8'h00);
    end
    chk("int_q_empty", 8'(exp_q.size()), 8'h00);
    rd(16'hFF01, "int_sb", 8'hFF);
    rd(16'hFF02, "int_sc", 8'h7F);
    chk("int_sout_idle", {7'd0, sout}, 8'h01);

    // 3: external clock, 8 pulses of sclk_i
    sin = 1'b0;
    cpu_wr(16'hFF01, 8'h3C);
    cpu_wr(16'hFF02, 8'h80);
    exp_q.push_back(8'h00);
    i0 = irq_cnt;
    rd(16'hFF02, "ext_sc_busy", 8'hFE);
    for (int p = 0; p < 8; p++) begin
      sclk_i = 1'b1;
      wait_cyc(4);
      sclk_i = 1'b0;
      wait_cyc(4);
      if (p == 6) chk("ext_no_early_irq", 8'(irq_cnt - i0), 8'h00);
    end
    wait_cyc(5);
    chk("ext_irq_once", 8'(irq_cnt - i0), 8'h01);
    e = exp_q.pop_front();
    rd(16'hFF01, "ext_sb", e);
    rd(16'hFF02, "ext_sc", 8'h7E);
    chk("ext_sclk_o", {7'd0, sclk_o}, 8'h01);

    // 4: abort after 3 bits
    sin = 1'b1;
    cpu_wr(16'hFF01, 8'h96);
    cpu_wr(16'hFF02, 8'h81);
    i0 = irq_cnt;
    wait_cyc(3 * N + 2);
    cpu_wr(16'hFF02, 8'h01);
    wait_cyc(100);
    chk("abort_no_irq", 8'(irq_cnt - i0), 8'h00);
    rd(16'hFF02, "abort_sc", 8'h7F);
    rd(16'hFF01, "abort_sb", 8'hB7);
    chk("abort_sout", {7'd0, sout}, 8'h01);
    chk("abort_sclk", {7'd0, sclk_o}, 8'h01);

    // 5: reset in the middle of bit 5
    cpu_wr(16'hFF02, 8'h81);
    i0 = irq_cnt;
    wait_cyc(5 * N + 2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mrst_sout", {7'd0, sout}, 8'h01);
    chk("mrst_sclk", {7'd0, sclk_o}, 8'h01);
    chk("mrst_irq", {7'd0, irq_serial}, 8'h00);
    rd(16'hFF01, "mrst_sb", 8'h00);
    rd(16'hFF02, "mrst_sc", 8'h7E);
    wait_cyc(100);
    chk("mrst_no_irq", 8'(irq_cnt - i0), 8'h00);

`ifdef SERIAL_CAPTURE_EN
    // 6: capture port
    chk("cap_rst", {7'd0, cap_valid}, 8'h00);
    cpu_wr(16'hFF01, 8'h48);
    cpu_wr(16'hFF02, 8'h81);
    @(negedge clk);
    chk("cap_valid", {7'd0, cap_valid}, 8'h01);
    chk("cap_data", cap_data, 8'h48);
    @(negedge clk);
    chk("cap_one_cycle", {7'd0, cap_valid}, 8'h00);
    cpu_wr(16'hFF02, 8'h80);
    @(negedge clk);
    chk("cap_80_none", {7'd0, cap_valid}, 8'h00);
    @(negedge clk);
    chk("cap_80_none2", {7'd0, cap_valid}, 8'h00);
    cpu_wr(16'hFF02, 8'h00);
`endif

    wait_cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
